// File: rtl/alu_shift_pkg.sv
// Shared definitions for the ALU shift path.
// Op encodings and width helpers.
package alu_shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_op_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/shift_pipe_slice.sv
// One valid/ready register slice of the shifter pipeline.
// Holds its payload while stalled; flush drops the valid bit only.
module shift_pipe_slice #(
  parameter int PW = 8
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [PW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [PW-1:0] out_data_o
);

  assign in_ready_o = !out_valid_o || out_ready_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (in_ready_o) begin
      out_valid_o <= in_valid_i;
      if (in_valid_i) out_data_o <= in_data_i;
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined log barrel shifter: SLL/SRL/SRA/ROR.
// Mux levels are grouped between PIPE_STAGES register slices.
module barrel_shifter_pipe
  import alu_shift_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 1,
  parameter int TAG_W       = 4
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [WIDTH-1:0]        in_data_i,
  input  logic [clog2(WIDTH)-1:0] in_shamt_i,
  input  logic [1:0]              in_op_i,
  input  logic [TAG_W-1:0]        in_tag_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [WIDTH-1:0]        out_data_o,
  output logic [TAG_W-1:0]        out_tag_o
);

  localparam int L  = clog2(WIDTH);
  localparam int SW = L;
  localparam int G  = (L + PIPE_STAGES - 1) / PIPE_STAGES;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    shift_op_e        op;
    logic             sign;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] data;
  } slot_t;

  localparam int PW = $bits(slot_t);

  function automatic logic [WIDTH-1:0] lvl(
    input logic [WIDTH-1:0] d,
    input shift_op_e        op,
    input logic             s,
    input int               amt
  );
    logic [WIDTH-1:0] r;
    unique case (op)
      SHIFT_SLL: r = d << amt;
      SHIFT_SRL: r = d >> amt;
      SHIFT_SRA: r = (d >> amt) | ({WIDTH{s}} << (WIDTH - amt));
      default:   r = (d >> amt) | (d << (WIDTH - amt));
    endcase
    return r;
  endfunction

  slot_t pl  [PIPE_STAGES+1];
  logic  vld [PIPE_STAGES+1];
  logic  rdy [PIPE_STAGES+1];

  // Sign is latched at accept so later SRA levels see the original MSB.
  always_comb begin
    pl[0]       = '0;
    pl[0].tag   = in_tag_i;
    pl[0].op    = shift_op_e'(in_op_i);
    pl[0].sign  = in_data_i[WIDTH-1];
    pl[0].shamt = in_shamt_i;
    pl[0].data  = in_data_i;
  end

  assign vld[0]           = in_valid_i && !flush_i;
  assign rdy[PIPE_STAGES] = out_ready_i;
  assign in_ready_o       = rdy[0] && !flush_i;

  for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
    localparam int LO = i * G;
    localparam int HI = ((i + 1) * G > L) ? L : (i + 1) * G;

    slot_t nx;

    always_comb begin
      nx = pl[i];
      for (int k = LO; k < HI; k++) begin
        if (nx.shamt[k[SW-1:0]])
          nx.data = lvl(nx.data, nx.op, nx.sign, 1 << k);
      end
    end

    shift_pipe_slice #(
      .PW(PW)
    ) u_slice (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .flush_i    (flush_i),
      .in_valid_i (vld[i]),
      .in_ready_o (rdy[i]),
      .in_data_i  (nx),
      .out_valid_o(vld[i+1]),
      .out_ready_i(rdy[i+1]),
      .out_data_o (pl[i+1])
    );
  end

  assign out_valid_o = vld[PIPE_STAGES];
  assign out_data_o  = pl[PIPE_STAGES].data;
  assign out_tag_o   = pl[PIPE_STAGES].tag;

  logic unused_tail;
  assign unused_tail = ^{pl[PIPE_STAGES].op,
                         pl[PIPE_STAGES].sign,
                         pl[PIPE_STAGES].shamt};

endmodule
